// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a request/response handshake.
// Requests are accepted in IDLE, the storage access happens in ACCESS, and the
// formatted response is held in RESP until the consumer takes it.
//
// Handshake: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both 1; a response transfers on a rising edge where
// o_rsp_valid and i_rsp_ready are both 1. Response outputs stay stable while
// o_rsp_valid is high and i_rsp_ready is low.
//
// Optional feature macro: MEM_RSP_ALIGN_CHECK_EN
//   defined   - misaligned half/word accesses and reserved types return
//               o_rsp_err = 1, rdata 0, and never write.
//   undefined - no error detection; half ignores addr[0], word ignores
//               addr[1:0], reserved types act as word.
//
// Ports:
//   clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready    request handshake
//   i_req_write, i_req_addr,
//   i_req_wdata, i_req_type      request payload (type: 000 LB, 001 LH,
//                                010 W, 100 LBU, 101 LHU)
//   o_rsp_valid / i_rsp_ready    response handshake
//   o_rsp_rdata, o_rsp_err       response payload
//   o_dbg_state                  current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
module mem_responder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    input  logic [2:0]        i_req_type,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [1:0]        o_dbg_state
);

    localparam int DEPTH = 1 << (ADDR_W - 2);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t state;

    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        type_q;

    // Storage is deliberately outside the reset domain: contents survive reset.
    logic [31:0] mem [DEPTH];

    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane;
    logic              is_byte;
    logic              is_half;
    logic              req_err;
    logic [3:0]        be;
    logic [31:0]       wr_data;
    logic [31:0]       rd_word;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       load_data;
    logic              mem_we;

    assign word_idx = addr_q[ADDR_W-1:2];
    assign lane     = addr_q[1:0];
    assign rd_word  = mem[word_idx];

    always_comb begin
        is_byte = (type_q[1:0] == 2'b00);
        is_half = (type_q[1:0] == 2'b01);

`ifdef MEM_RSP_ALIGN_CHECK_EN
        // Legal types are 000, 001, 010, 100, 101; anything else is reserved.
        req_err = (type_q == 3'b011) || (type_q[2:1] == 2'b11)
               || (is_half && lane[0])
               || ((type_q == 3'b010) && (lane != 2'b00));
`else
        req_err = 1'b0;
`endif

        // Store data is replicated across lanes so the byte enables alone
        // select which lanes change.
        be      = 4'b1111;
        wr_data = wdata_q;
        if (is_byte) begin
            be      = 4'b0001 << lane;
            wr_data = {4{wdata_q[7:0]}};
        end else if (is_half) begin
            be      = lane[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{wdata_q[15:0]}};
        end

        case (lane)
            2'd0:    byte_val = rd_word[7:0];
            2'd1:    byte_val = rd_word[15:8];
            2'd2:    byte_val = rd_word[23:16];
            default: byte_val = rd_word[31:24];
        endcase
        half_val = lane[1] ? rd_word[31:16] : rd_word[15:0];

        // type_q[2] selects zero-extension.
        if (is_byte) begin
            load_data = type_q[2] ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
        end else if (is_half) begin
            load_data = type_q[2] ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
        end else begin
            load_data = rd_word;
        end
    end

    // Only ACCESS writes; an async reset forces IDLE, which cancels the write.
    assign mem_we = (state == S_ACCESS) && write_q && !req_err;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (mem_we && be[k]) begin
                mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            type_q      <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        write_q <= i_req_write;
                        addr_q  <= i_req_addr;
                        wdata_q <= i_req_wdata;
                        type_q  <= i_req_type;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= req_err;
                    o_rsp_rdata <= (write_q || req_err) ? 32'd0 : load_data;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Ready is held low while reset is asserted, high in IDLE otherwise.
    assign o_req_ready = (state == S_IDLE) && i_rst_n;
    assign o_dbg_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: word/byte/half stores and loads, latency,
// back-pressure, request spacing, alignment handling and reset during ACCESS.
module tb_mem_responder;

  localparam logic [2:0] T_LB  = 3'b000;
  localparam logic [2:0] T_LH  = 3'b001;
  localparam logic [2:0] T_LW  = 3'b010;
  localparam logic [2:0] T_RSV = 3'b011;
  localparam logic [2:0] T_LBU = 3'b100;
  localparam logic [2:0] T_LHU = 3'b101;

  logic        clk;
  logic        i_rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [7:0]  i_req_addr;
  logic [31:0] i_req_wdata;
  logic [2:0]  i_req_type;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [1:0]  o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  mem_responder #(.ADDR_W(8)) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_write (i_req_write),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .i_req_type  (i_req_type),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_dbg_state (o_dbg_state)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: one full request/response transaction. lat is the number of
  // edges from the accept edge to the first edge that samples o_rsp_valid
  // high, or -1 on timeout.
  task automatic do_req(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [2:0] ty, output logic [31:0] rd, output logic e,
                        output int lat);
    int k;
    rd  = '0;
    e   = 1'b0;
    lat = -1;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = a;
    i_req_wdata = wd;
    i_req_type  = ty;
    k = 0;
    while (!o_req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!o_req_ready) begin
      i_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!o_rsp_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!o_rsp_valid) return;
    lat = k + 1;
    rd  = o_rsp_rdata;
    e   = o_rsp_err;
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 i_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    i_req_addr  = '0;
    i_req_wdata = '0;
    i_req_type  = '0;
    i_rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (o_req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", o_req_ready); end
    n_vec++;
    if (o_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", o_rsp_valid); end
    n_vec++;
    if (o_rsp_rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", o_rsp_rdata); end
    n_vec++;
    if (o_rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", o_rsp_err); end
    i_rst_n = 1'b1;
    #1;
    n_vec++;
    if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", o_req_ready); end
    n_vec++;
    if (o_dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", o_dbg_state); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 8'h10, 32'hA1B2C3D4, T_LW, rd, e, lat);
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    n_vec++;
    if (rd !== 32'd0 || e !== 1'b0) begin n_err++; $display("FAIL sw_rsp: got %h/%b expected 0/0", rd, e); end
    do_req(1'b0, 8'h10, 32'd0, T_LW, rd, e, lat);
    n_vec++;
    if (lat !== 2) begin n_err++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    n_vec++;
    if (rd !== 32'hA1B2C3D4 || e !== 1'b0) begin n_err++; $display("FAIL lw_10: got %h/%b expected a1b2c3d4/0", rd, e); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 8'h11, 32'h000000EE, T_LB, rd, e, lat);
    do_req(1'b0, 8'h10, 32'd0, T_LW, rd, e, lat);
    n_vec++;
    if (rd !== 32'hA1B2EED4) begin n_err++; $display("FAIL sb_merge: got %h expected a1b2eed4", rd); end
    do_req(1'b0, 8'h11, 32'd0, T_LB, rd, e, lat);
    n_vec++;
    if (rd !== 32'hFFFFFFEE) begin n_err++; $display("FAIL lb_11: got %h expected ffffffee", rd); end
    do_req(1'b0, 8'h11, 32'd0, T_LBU, rd, e, lat);
    n_vec++;
    if (rd !== 32'h000000EE) begin n_err++; $display("FAIL lbu_11: got %h expected 000000ee", rd); end
    do_req(1'b0, 8'h10, 32'd0, T_LB, rd, e, lat);
    n_vec++;
    if (rd !== 32'hFFFFFFD4) begin n_err++; $display("FAIL lb_10: got %h expected ffffffd4", rd); end
    do_req(1'b0, 8'h13, 32'd0, T_LBU, rd, e, lat);
    n_vec++;
    if (rd !== 32'h000000A1) begin n_err++; $display("FAIL lbu_13: got %h expected 000000a1", rd); end
    do_req(1'b0, 8'h12, 32'd0, T_LB, rd, e, lat);
    n_vec++;
    if (rd !== 32'hFFFFFFB2) begin n_err++; $display("FAIL lb_12: got %h expected ffffffb2", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 8'h22, 32'h00008001, T_LH, rd, e, lat);
    do_req(1'b0, 8'h22, 32'd0, T_LH, rd, e, lat);
    n_vec++;
    if (rd !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_22: got %h expected ffff8001", rd); end
    do_req(1'b0, 8'h22, 32'd0, T_LHU, rd, e, lat);
    n_vec++;
    if (rd !== 32'h00008001) begin n_err++; $display("FAIL lhu_22: got %h expected 00008001", rd); end
    do_req(1'b0, 8'h20, 32'd0, T_LW, rd, e, lat);
    n_vec++;
    if (rd[31:16] !== 16'h8001) begin n_err++; $display("FAIL lw_20_hi: got %h expected 8001", rd[31:16]); end
    // byte store into the top lane keeps lane 2
    do_req(1'b1, 8'h23, 32'hFFFFFF12, T_LBU, rd, e, lat);
    do_req(1'b0, 8'h20, 32'd0, T_LW, rd, e, lat);
    n_vec++;
    if (rd[31:16] !== 16'h1201) begin n_err++; $display("FAIL sb_23_hi: got %h expected 1201", rd[31:16]); end
    do_req(1'b0, 8'h10, 32'd0, T_LHU, rd, e, lat);
    n_vec++;
    if (rd !== 32'h0000EED4) begin n_err++; $display("FAIL lhu_10: got %h expected 0000eed4", rd); end
  endtask

  task automatic test_backpressure();
    int k;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_req_addr  = 8'h10;
    i_req_type  = T_LW;
    k = 0;
    while (!o_req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    // a competing store that must be ignored while busy
    #1;
    i_req_write = 1'b1;
    i_req_addr  = 8'h20;
    i_req_wdata = 32'h0;
    k = 0;
    @(negedge clk);
    while (!o_rsp_valid && k < 10) begin @(negedge clk); k++; end
    n_vec++;
    if (o_rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_timeout: got %b expected 1", o_rsp_valid); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (o_rsp_rdata !== 32'hA1B2EED4 || o_req_ready !== 1'b0 || o_rsp_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got rdata %h ready %b valid %b expected a1b2eed4 0 1",
                 c, o_rsp_rdata, o_req_ready, o_rsp_valid);
      end
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 i_rsp_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: got valid %b ready %b expected 0 1", o_rsp_valid, o_req_ready);
    end
    begin
      logic [31:0] rd; logic e; int lat;
      do_req(1'b0, 8'h20, 32'd0, T_LW, rd, e, lat);
      n_vec++;
      if (rd[31:16] !== 16'h1201) begin n_err++; $display("FAIL bp_no_store: got %h expected 1201", rd[31:16]); end
    end
  endtask

  task automatic test_align();
    logic [31:0] rd; logic e; int lat;
`ifdef MEM_RSP_ALIGN_CHECK_EN
    do_req(1'b1, 8'h13, 32'hFFFFFFFF, T_LW, rd, e, lat);
    n_vec++;
    if (e !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL sw_13_err: got %h/%b expected 0/1", rd, e); end
    do_req(1'b0, 8'h10, 32'd0, T_LW, rd, e, lat);
    n_vec++;
    if (rd !== 32'hA1B2EED4 || e !== 1'b0) begin n_err++; $display("FAIL sw_13_nowrite: got %h/%b expected a1b2eed4/0", rd, e); end
    do_req(1'b0, 8'h23, 32'd0, T_LH, rd, e, lat);
    n_vec++;
    if (e !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL lh_23_err: got %h/%b expected 0/1", rd, e); end
    do_req(1'b0, 8'h10, 32'd0, T_RSV, rd, e, lat);
    n_vec++;
    if (e !== 1'b1 || rd !== 32'd0) begin n_err++; $display("FAIL rsv_err: got %h/%b expected 0/1", rd, e); end
`else
    do_req(1'b0, 8'h12, 32'd0, T_RSV, rd, e, lat);
    n_vec++;
    if (rd !== 32'hA1B2EED4 || e !== 1'b0) begin n_err++; $display("FAIL rsv_as_word: got %h/%b expected a1b2eed4/0", rd, e); end
    do_req(1'b0, 8'h13, 32'd0, T_LW, rd, e, lat);
    n_vec++;
    if (rd !== 32'hA1B2EED4 || e !== 1'b0) begin n_err++; $display("FAIL lw_13_ignore: got %h/%b expected a1b2eed4/0", rd, e); end
    do_req(1'b0, 8'h23, 32'd0, T_LH, rd, e, lat);
    n_vec++;
    if (rd !== 32'h00001201 || e !== 1'b0) begin n_err++; $display("FAIL lh_23_ignore: got %h/%b expected 00001201/0", rd, e); end
`endif
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int nrsp;
    nrsp = 0;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_req_addr  = 8'h10;
    i_req_type  = T_LW;
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      if (o_req_ready) acc.push_back(c);
      if (o_rsp_valid) begin
        nrsp++;
        n_vec++;
        if (o_rsp_rdata !== 32'hA1B2EED4) begin n_err++; $display("FAIL b2b_rdata: got %h expected a1b2eed4", o_rsp_rdata); end
      end
    end
    i_req_valid = 1'b0;
    @(posedge clk);
    #1 i_rsp_ready = 1'b0;
    n_vec++;
    if (acc.size() !== 3) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 3", acc.size()); end
    else begin
      n_vec++;
      if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d,%0d expected 3,3", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    n_vec++;
    if (nrsp !== 3) begin n_err++; $display("FAIL b2b_responses: got %0d expected 3", nrsp); end
  endtask

  task automatic test_reset_access();
    logic [31:0] rd; logic e; int lat; int k;
    do_req(1'b1, 8'h30, 32'hCAFEF00D, T_LW, rd, e, lat);
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_write = 1'b1;
    i_req_addr  = 8'h30;
    i_req_wdata = 32'h12345678;
    i_req_type  = T_LW;
    k = 0;
    while (!o_req_ready && k < 20) begin @(negedge clk); k++; end
    @(posedge clk);
    #1;
    i_req_valid = 1'b0;
    n_vec++;
    if (o_dbg_state !== 2'd1) begin n_err++; $display("FAIL rst_in_access_state: got %0d expected 1", o_dbg_state); end
    i_rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_in_access_out: got valid %b ready %b expected 0 0", o_rsp_valid, o_req_ready);
    end
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    #1;
    n_vec++;
    if (o_req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", o_req_ready); end
    do_req(1'b0, 8'h30, 32'd0, T_LW, rd, e, lat);
    n_vec++;
    if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL rst_write_suppressed: got %h expected cafef00d", rd); end
    do_req(1'b0, 8'h10, 32'd0, T_LW, rd, e, lat);
    n_vec++;
    if (rd !== 32'hA1B2EED4) begin n_err++; $display("FAIL mem_survives_reset: got %h expected a1b2eed4", rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_backpressure();
    test_align();
    test_back_to_back();
    test_reset_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; storage depth SHALL be 2^(ADDR_W-2) 32-bit words.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_req_valid  input  1  request present.
REQ-005 o_req_ready  output  1  responder accepts a request this cycle.
REQ-006 i_req_write  input  1  1 = store, 0 = load.
REQ-007 i_req_addr  input  ADDR_W  byte address.
REQ-008 i_req_wdata  input  32  store data, right-justified.
REQ-009 i_req_type  input  3  000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; others reserved.
REQ-010 o_rsp_valid  output  1  response present.
REQ-011 i_rsp_ready  input  1  consumer accepts the response.
REQ-012 o_rsp_rdata  output  32  formatted load data; 0 for stores and errors.
REQ-013 o_rsp_err  output  1  request rejected: misaligned or reserved type.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS and RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-015 IDLE: on i_req_valid & o_req_ready, latch write/addr/wdata/type and go to ACCESS; otherwise stay.
REQ-016 ACCESS: perform the store byte-write or the synchronous word read at addr[ADDR_W-1:2]; go to RESP unconditionally.
REQ-017 RESP: o_rsp_valid = 1 with stable rdata/err; on i_rsp_ready go to IDLE; otherwise hold.
REQ-018 Latency: request accepted at edge N; o_rsp_valid SHALL be high from edge N+2; minimum spacing between accepted requests SHALL be 3 cycles.
REQ-019 Byte lanes little-endian: lane k = bits 8k+7:8k, at byte address with addr[1:0] = k.
REQ-020 Store byte (type x00) SHALL write wdata[7:0] to lane addr[1:0] only; store half (x01) SHALL write wdata[15:0] to lanes 2*addr[1] and 2*addr[1]+1; word (010) SHALL write all lanes; unwritten lanes SHALL be preserved.
REQ-021 Loads SHALL extract the addressed byte/half and sign-extend (000, 001) or zero-extend (100, 101) to 32 bits; word loads unchanged.
REQ-022 A load issued after a store to the same word SHALL return the stored data (no stale read).
REQ-023 Address wrap: none; addr is used modulo 2^ADDR_W.
REQ-024 i_req_valid outside IDLE SHALL be ignored; inputs are not sampled until o_req_ready is 1.

Reset
REQ-025 On i_rst_n low: state = IDLE, o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0, o_req_ready = 0 while reset is asserted, 1 in the first cycle after release.
REQ-026 Reset asserted in ACCESS before the edge that performs the write SHALL suppress the write; reset in RESP SHALL drop the pending response.
REQ-027 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MEM_RSP_ALIGN_CHECK_EN: when defined, a half access with addr[0] = 1, a word access with addr[1:0] != 0, or a reserved type SHALL set o_rsp_err = 1, suppress any write and return rdata 0.
REQ-029 Without MEM_RSP_ALIGN_CHECK_EN: o_rsp_err SHALL be tied 0, half accesses SHALL ignore addr[0], word accesses SHALL ignore addr[1:0], and reserved types SHALL behave as word.

Verification
REQ-030 SW addr 0x10 data 0xA1B2C3D4, then LW 0x10 -> rdata 0xA1B2C3D4, err 0, o_rsp_valid rising 2 cycles after each accept.
REQ-031 After REQ-030, SB addr 0x11 data 0x000000EE, then LW 0x10 -> 0xA1B2EED4; LB 0x11 -> 0xFFFFFFEE; LBU 0x11 -> 0x000000EE.
REQ-032 SH addr 0x22 data 0x00008001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> upper half 0x8001.
REQ-033 Hold i_rsp_ready = 0 for 5 cycles in RESP with i_req_valid = 1 -> rdata stable, o_req_ready = 0, no second request accepted.
REQ-034 With MEM_RSP_ALIGN_CHECK_EN: SW addr 0x13 data 0xFFFFFFFF -> err 1, rdata 0; subsequent LW 0x10 -> 0xA1B2EED4, unchanged.
REQ-035 Assert i_rst_n low in ACCESS of SW addr 0x30 data 0x12345678, release, then LW 0x30 -> previous contents, not 0x12345678.
